// File: rtl/axi_read_responder.sv
// AXI read-only slave that serves bursts from a combinational byte array.
// One transaction is outstanding at a time: the address channel is only
// ready in IDLE, and the data channel only valid in SEND.
module axi_read_responder #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4095:0][7:0]    mem,
  input  logic [WIDTH/8-1:0]    arid,
  input  logic [WIDTH-1:0]      araddr,
  input  logic [WIDTH/8-1:0]    arlen,
  input  logic [SIZE-1:0]       arsize,
  input  logic [SIZE-2:0]       arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [WIDTH/8-1:0]    rid,
  output logic [WIDTH-1:0]      rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [SIZE-2:0] BURST_FIXED = 'd0;
  localparam logic [SIZE-2:0] BURST_INCR  = 'd1;
  localparam logic [SIZE-2:0] BURST_WRAP  = 'd2;
  localparam logic [SIZE-2:0] BURST_RSVD  = 'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]          state_reg;
  logic                started_reg;  // low until the first edge after reset
  logic [WIDTH/8-1:0]  id_reg;
  logic [WIDTH-1:0]    addr_reg;
  logic [WIDTH/8-1:0]  len_reg;
  logic [SIZE-1:0]     size_reg;
  logic [SIZE-2:0]     burst_reg;
  logic [WIDTH/8-1:0]  cnt_reg;
  logic                err_reg;

  // ---------------- request decode (evaluated on the AR handshake) ----------
  logic [WIDTH-1:0] ar_bytes;
  logic [WIDTH-1:0] ar_len_ext;
  logic [WIDTH-1:0] ar_size_ext;
  logic             ar_wrap_len_ok;
  logic             ar_err;

  assign ar_bytes    = {{(WIDTH-1){1'b0}}, 1'b1} << arsize;
  assign ar_len_ext  = {{(WIDTH-WIDTH/8){1'b0}}, arlen};
  assign ar_size_ext = {{(WIDTH-SIZE){1'b0}}, arsize};
  assign ar_wrap_len_ok = (ar_len_ext == 32'd1) || (ar_len_ext == 32'd3) ||
                          (ar_len_ext == 32'd7) || (ar_len_ext == 32'd15);

  // Illegal requests still run the full beat count, but answer SLVERR / zero data.
  always_comb begin
    ar_err = 1'b0;
    if (arburst == BURST_RSVD)
      ar_err = 1'b1;
    if (ar_size_ext > 32'd2)
      ar_err = 1'b1;
    if (arburst == BURST_WRAP && !ar_wrap_len_ok)
      ar_err = 1'b1;
    if (arburst == BURST_WRAP && ((araddr & (ar_bytes - 32'd1)) != '0))
      ar_err = 1'b1;
  end

  // ---------------- next beat address --------------------------------------
  logic [WIDTH-1:0] bytes;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] incr_addr;
  logic [WIDTH-1:0] wrap_total;
  logic [WIDTH-1:0] wrap_bound;
  logic [WIDTH-1:0] next_addr;

  assign bytes      = {{(WIDTH-1){1'b0}}, 1'b1} << size_reg;
  assign aligned    = addr_reg & ~(bytes - 32'd1);
  assign incr_addr  = aligned + bytes;
  assign wrap_total = ({{(WIDTH-WIDTH/8){1'b0}}, len_reg} + 32'd1) << size_reg;
  assign wrap_bound = addr_reg & ~(wrap_total - 32'd1);

  // FIXED holds, INCR steps by the beat size, WRAP folds back at the window end.
  always_comb begin
    next_addr = addr_reg;
    case (burst_reg)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (incr_addr == wrap_bound + wrap_total) ? wrap_bound : incr_addr;
      default:    next_addr = addr_reg;
    endcase
  end

  // ---------------- handshake outputs --------------------------------------
  assign arready = (state_reg == IDLE) && started_reg;
  assign rvalid  = (state_reg == SEND);
  assign rid     = id_reg;
  assign rlast   = (state_reg == SEND) && (cnt_reg == len_reg);
  assign rresp   = ((state_reg == SEND) && err_reg) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read data lanes ----------------------------------------
  // Active lanes run from the start byte up to the end of the size-aligned
  // container; everything else reads as zero (narrow / unaligned transfers).
  logic [1:0] lane_lo;
  logic [1:0] lane_hi;

  assign lane_lo = addr_reg[1:0];
  assign lane_hi = aligned[1:0] + bytes[1:0] - 2'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic lane_en;
    assign lane_en = (state_reg == SEND) && !err_reg &&
                     (LANE >= lane_lo) && (LANE <= lane_hi);
    assign rdata[8*gi +: 8] = lane_en ? mem[{addr_reg[11:2], LANE}] : 8'h00;
  end

  // ---------------- control FSM and latched request ------------------------
  // Accept a request in IDLE, stream arlen+1 beats in SEND, then return.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      started_reg <= 1'b0;
      id_reg      <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (arvalid && arready) begin
            id_reg    <= arid;
            addr_reg  <= araddr;
            len_reg   <= arlen;
            size_reg  <= arsize;
            burst_reg <= arburst;
            err_reg   <= ar_err;
            cnt_reg   <= '0;
            state_reg <= SEND;
          end
        end
        default: begin
          if (rready) begin
            if (cnt_reg == len_reg) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg  <= cnt_reg + {{(WIDTH/8-1){1'b0}}, 1'b1};
              addr_reg <= next_addr;
            end
          end
        end
      endcase
    end
  end

endmodule
